memmap_ctrl: RTL and testbench

- Parametrised memory-mapping controller for the 6801 system bus; successor to the single-register page selector.
- Maps each 8 KB CPU slot independently onto a larger external SRAM, with per-slot enable and write-protect.
- Detects write-protect faults and raises an IRQ; generates CPU hold wait states for slow external memory.
- Sits between the CPU address bus and the EXT_* SRAM pins. Registers decode at $E6F0.

---
 rtl/memmap_ctrl.sv | 112 +++++++++++
 tb/tb_memmap_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/memmap_ctrl.sv
// memmap_ctrl: per-slot CPU-to-SRAM address mapper with write protect, fault IRQ and wait-state hold
module memmap_ctrl #(
  parameter int SLOT_BITS = 3,
  parameter int PAGE_W    = 4,
  parameter int WAIT_W    = 3,
  parameter int WAIT_RST  = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             irq,
  input  logic [3:0]                       AD,
  input  logic [7:0]                       DI,
  output logic [7:0]                       DO,
  input  logic                             rw,
  input  logic                             cs,
  input  logic [15:0]                      cpu_addr,
  input  logic                             cpu_rw,
  input  logic                             cpu_vma,
  input  logic                             ext_sel,
  output logic [PAGE_W+16-SLOT_BITS-1:0]   ext_addr,
  output logic                             ext_wr_en,
  output logic                             hold,
  output logic                             bram_disable
);
  localparam int NS    = 1 << SLOT_BITS;
  localparam int OFF_W = 16 - SLOT_BITS;
  localparam int EXT_W = PAGE_W + OFF_W;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  logic [NS-1:0]        en_q, wp_q;
  logic [PAGE_W-1:0]    page_q [NS];
  logic                 bram_q, irq_en_q, flag_q;
  logic [WAIT_W-1:0]    wait_q, cnt_q;
  logic [SLOT_BITS-1:0] fslot_q;
  state_t               state_q;
  logic [SLOT_BITS-1:0] slot, ad_slot;
  logic                 ext_acc, fault, wr, clr, is_slot, unused_bits;
  assign slot         = cpu_addr[15 -: SLOT_BITS];
  assign ad_slot      = AD[SLOT_BITS-1:0];
  assign is_slot      = 32'(AD) < NS;
  assign ext_acc      = cpu_vma && ext_sel;
  assign fault        = ext_acc && !cpu_rw && en_q[slot] && wp_q[slot];
  assign wr           = cs && !rw;
  assign clr          = wr && AD == 4'd9 && DI[0];
  assign unused_bits  = ^DI;
  assign ext_addr     = en_q[slot] ? {page_q[slot], cpu_addr[OFF_W-1:0]} : EXT_W'(cpu_addr);
  assign ext_wr_en    = !cpu_rw && ext_acc && !(en_q[slot] && wp_q[slot]);
  assign irq          = flag_q && irq_en_q;
  assign bram_disable = bram_q;
  // The IDLE term raises hold in the very cycle the access is first seen; reset suppresses it
  assign hold = state_q == WAIT || (state_q == IDLE && ext_acc && wait_q != '0 && !rst);
  // Register file and fault capture; a new fault beats a simultaneous clear, otherwise the first fault is kept
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= '0;
      wp_q     <= '0;
      for (int i = 0; i < NS; i++) page_q[i] <= '0;
      bram_q   <= 1'b0;
      irq_en_q <= 1'b0;
      wait_q   <= WAIT_W'(WAIT_RST);
      flag_q   <= 1'b0;
      fslot_q  <= '0;
    end else begin
      if (fault && (!flag_q || clr)) begin
        flag_q  <= 1'b1;
        fslot_q <= slot;
      end else if (clr) flag_q <= 1'b0;
      if (wr && is_slot) begin
        en_q[ad_slot]   <= DI[7];
        wp_q[ad_slot]   <= DI[6];
        page_q[ad_slot] <= DI[PAGE_W-1:0];
      end
      if (wr && AD == 4'd8) begin
        bram_q   <= DI[0];
        irq_en_q <= DI[1];
        wait_q   <= DI[2 +: WAIT_W];
      end
    end
  end
  // Wait-state FSM: cnt_q holds the WAIT cycles still to go, so total hold equals the wait count
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (ext_acc && wait_q != '0) begin
          cnt_q   <= wait_q - 1'b1;
          state_q <= wait_q == WAIT_W'(1) ? ACK : WAIT;
        end
        WAIT: if (cnt_q == WAIT_W'(1)) state_q <= ACK;
              else cnt_q <= cnt_q - 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
  // Register read mux; unused bits and unmapped addresses read as zero
  always_comb begin
    DO = 8'h00;
    if (is_slot) begin
      DO[7]          = en_q[ad_slot];
      DO[6]          = wp_q[ad_slot];
      DO[PAGE_W-1:0] = page_q[ad_slot];
    end else if (AD == 4'd8) begin
      DO[0]          = bram_q;
      DO[1]          = irq_en_q;
      DO[2 +: WAIT_W] = wait_q;
    end else if (AD == 4'd9) begin
      DO[0]             = flag_q;
      DO[4 +: SLOT_BITS] = fslot_q;
    end
  end
endmodule

// File: tb/tb_memmap_ctrl.sv
// tb_memmap_ctrl: directed and random checks of memmap_ctrl against a behavioural model
module tb_memmap_ctrl;
  logic        clk = 1'b0, rst;
  logic [3:0]  AD;
  logic [7:0]  DI, DO;
  logic        rw, cs, cpu_rw, cpu_vma, ext_sel;
  logic [15:0] cpu_addr;
  logic [16:0] ext_addr;
  logic        ext_wr_en, hold, bram_disable, irq;
  int          n_chk = 0, n_pass = 0;
  bit          m_en [8], m_wp [8];
  bit [3:0]    m_page [8];
  bit          m_bram, m_irqen, m_flag, m_ack;
  bit [2:0]    m_wc, m_fslot;
  int          m_rem;
  logic [4:0]  hseq;
  int          hcnt;
  always #5 clk = ~clk;
  memmap_ctrl dut (
    .clk(clk), .rst(rst), .irq(irq), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
    .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_vma(cpu_vma), .ext_sel(ext_sel),
    .ext_addr(ext_addr), .ext_wr_en(ext_wr_en), .hold(hold), .bram_disable(bram_disable)
  );
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  function automatic logic [7:0] m_do();
    if (AD < 4'd8) return {m_en[AD[2:0]], m_wp[AD[2:0]], 2'b00, m_page[AD[2:0]]};
    if (AD == 4'd8) return {3'b000, m_wc, m_irqen, m_bram};
    if (AD == 4'd9) return {1'b0, m_fslot, 3'b000, m_flag};
    return 8'h00;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_en[i] = 0; m_wp[i] = 0; m_page[i] = 0;
    end
    m_bram = 0; m_irqen = 0; m_wc = 3'd1; m_flag = 0; m_fslot = 0; m_rem = 0; m_ack = 0;
  endtask
  task automatic model_edge();
    bit [2:0] s = cpu_addr[15:13];
    bit trig = cpu_vma && ext_sel;
    bit wr = cs && !rw;
    bit clr = wr && AD == 4'd9 && DI[0];
    bit flt = trig && !cpu_rw && m_en[s] && m_wp[s];
    if (rst) begin
      model_reset();
      return;
    end
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) m_ack = 1;
    end else if (m_ack) m_ack = 0;
    else if (trig && m_wc != 0) begin
      m_rem = int'(m_wc) - 1;
      if (m_rem == 0) m_ack = 1;
    end
    if (flt && (!m_flag || clr)) begin
      m_flag = 1; m_fslot = s;
    end else if (clr) m_flag = 0;
    if (wr && AD < 4'd8) begin
      m_en[AD[2:0]] = DI[7]; m_wp[AD[2:0]] = DI[6]; m_page[AD[2:0]] = DI[3:0];
    end else if (wr && AD == 4'd8) begin
      m_bram = DI[0]; m_irqen = DI[1]; m_wc = DI[4:2];
    end
  endtask
  task automatic cyc();
    bit [2:0] s;
    bit hold_exp;
    @(negedge clk);
    s = cpu_addr[15:13];
    hold_exp = m_rem > 0 ? 1'b1 : m_ack ? 1'b0 : (cpu_vma && ext_sel && m_wc != 0 && !rst);
    chk("ext_addr", 32'(ext_addr), m_en[s] ? {15'b0, m_page[s], cpu_addr[12:0]} : {16'b0, cpu_addr});
    chk("ext_wr_en", 32'(ext_wr_en), 32'(!cpu_rw && cpu_vma && ext_sel && !(m_en[s] && m_wp[s])));
    chk("hold", 32'(hold), 32'(hold_exp));
    chk("DO", 32'(DO), 32'(m_do()));
    chk("irq", 32'(irq), 32'(m_flag && m_irqen));
    chk("bram_disable", 32'(bram_disable), 32'(m_bram));
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic reg_wr(input logic [3:0] a, input logic [7:0] d);
    cs = 1; rw = 0; AD = a; DI = d;
    cyc();
    cs = 0; rw = 1;
  endtask
  initial begin
    model_reset();
    rst = 1; cs = 0; rw = 1; AD = 0; DI = 0;
    cpu_addr = 0; cpu_rw = 1; cpu_vma = 0; ext_sel = 0;
    #1;
    cyc();
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      AD = 4'(i);
      #1 chk("reset_read", 32'(DO), i == 8 ? 32'h04 : 32'h00);
      cyc();
    end
    chk("reset_irq", 32'(irq), 0);
    chk("reset_hold", 32'(hold), 0);
    reg_wr(4'd6, 8'h85);
    cpu_addr = 16'hC123;
    #1 chk("map_en", 32'(ext_addr), 32'h0A123);
    reg_wr(4'd6, 8'h05);
    #1 chk("map_dis", 32'(ext_addr), 32'h0C123);
    reg_wr(4'd6, 8'hC5);
    reg_wr(4'd8, 8'h02);
    cpu_addr = 16'hC000; cpu_rw = 0; cpu_vma = 1; ext_sel = 1;
    #1 chk("wp_block", 32'(ext_wr_en), 0);
    cyc();
    cpu_vma = 0; cpu_rw = 1; AD = 4'd9;
    #1 chk("status_fault", 32'(DO), 32'h61);
    chk("irq_set", 32'(irq), 1);
    reg_wr(4'd9, 8'h01);
    #1 chk("irq_clr", 32'(irq), 0);
    reg_wr(4'd2, 8'hC3);
    cpu_addr = 16'hC000; cpu_rw = 0; cpu_vma = 1; ext_sel = 1;
    cyc();
    cpu_addr = 16'h4000;
    cyc();
    cpu_vma = 0; cpu_rw = 1; AD = 4'd9;
    #1 chk("first_fault_kept", 32'(DO), 32'h61);
    reg_wr(4'd9, 8'h01);
    reg_wr(4'd8, 8'h0C);
    cpu_addr = 16'h0000; cpu_vma = 1; ext_sel = 1;
    for (int k = 0; k < 5; k++) begin
      #1 hseq[k] = hold;
      cyc();
    end
    chk("hold_wait3", 32'(hseq), 32'b10111);
    cpu_vma = 0;
    cyc(); cyc(); cyc(); cyc();
    reg_wr(4'd8, 8'h00);
    cpu_vma = 1;
    hcnt = 0;
    for (int k = 0; k < 6; k++) begin
      #1 hcnt += int'(hold);
      cyc();
    end
    chk("hold_wait0", 32'(hcnt), 0);
    cpu_vma = 0;
    reg_wr(4'd8, 8'h0D);
    cpu_vma = 1;
    cyc(); cyc();
    rst = 1; cpu_vma = 0;
    cyc();
    rst = 0;
    #1 chk("rst_hold", 32'(hold), 0);
    AD = 4'd8;
    #1 chk("rst_ctrl", 32'(DO), 32'h04);
    AD = 4'd6;
    #1 chk("rst_slot", 32'(DO), 32'h00);
    cyc();
    for (int i = 0; i < 3000; i++) begin
      rst      = $urandom_range(0, 299) == 0;
      cs       = $urandom_range(0, 3) == 0;
      rw       = 1'($urandom);
      AD       = $urandom_range(0, 4) == 0 ? 4'($urandom) : 4'($urandom_range(0, 9));
      DI       = 8'($urandom);
      cpu_addr = 16'($urandom);
      cpu_rw   = 1'($urandom);
      cpu_vma  = $urandom_range(0, 3) != 0;
      ext_sel  = 1'($urandom);
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
